// File: rtl/hex_count_ctrl_pkg.sv
// Shared run-state type, timing defaults and count arithmetic for the hex counter controller.
package hex_count_ctrl_pkg;

   typedef enum logic {
      PAUSED   = 1'b0,
      COUNTING = 1'b1
   } run_state_e;

   localparam int CLK_HZ             = 16000000;
   localparam int DEB_MS             = 10;
   localparam int VALUE_W            = 16;
   localparam int DEB_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEB_MS;

   // Modulo-2^VALUE_W step; wraps naturally in both directions.
   function automatic logic [VALUE_W-1:0] step_value(input logic [VALUE_W-1:0] value,
                                                     input logic               down);
      return down ? value - VALUE_W'(1) : value + VALUE_W'(1);
   endfunction

endpackage

// File: rtl/hex_count_ctrl_btn_debounce.sv
// Two-flop synchroniser plus stable-count debouncer; emits a one-cycle pulse on each accepted press.
module btn_debounce
   import hex_count_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
   input  logic CLK,
   input  logic RST,
   input  logic raw_in,
   output logic level_out,
   output logic press_out
);

   localparam int            CW      = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);

   logic          meta_q, meta_d;
   logic          sync_q, sync_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The counter only runs while the synchronised level disagrees with the accepted one.
   always_comb begin
      meta_d  = raw_in;
      sync_d  = meta_q;
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (sync_q != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = sync_q;
            press_d = sync_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         meta_q  <= meta_d;
         sync_q  <= sync_d;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_out = level_q;
   assign press_out = press_q;

endmodule

// File: rtl/hex_count_ctrl.sv
// Prescaled 16-bit up/down counter with debounced run/pause and clear buttons, feeding the display stage.
module hex_count_ctrl
   import hex_count_ctrl_pkg::*;
#(
   parameter int                 TICK_DIV   = CLK_HZ,
   parameter int                 DEB_CYCLES = DEB_CYCLES_DEFAULT,
   parameter logic [VALUE_W-1:0] INIT_VALUE = 16'h0000
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               BTN_RUN,
   input  logic               BTN_CLR,
   input  logic               DIR,
   output logic [VALUE_W-1:0] VALUE,
   output logic               TICK,
   output logic               RUNNING
);

   localparam int            PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   logic               run_press, clr_press;
   logic               unused_run_level, unused_clr_level;
   logic               dir_meta_q, dir_meta_d;
   logic               dir_sync_q, dir_sync_d;
   run_state_e         state_q, state_d;
   logic [PW-1:0]      presc_q, presc_d;
   logic [VALUE_W-1:0] value_q, value_d;
   logic               tick_q, tick_d;
   logic               step;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_btn (
      .CLK       (CLK),
      .RST       (RST),
      .raw_in    (BTN_RUN),
      .level_out (unused_run_level),
      .press_out (run_press)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_btn (
      .CLK       (CLK),
      .RST       (RST),
      .raw_in    (BTN_CLR),
      .level_out (unused_clr_level),
      .press_out (clr_press)
   );

   // Clear is applied last so it overrides a coinciding step and suppresses its tick.
   always_comb begin
      dir_meta_d = DIR;
      dir_sync_d = dir_meta_q;
      step       = (state_q == COUNTING) && (presc_q == PRESC_MAX);
      state_d    = state_q;
      presc_d    = presc_q;
      value_d    = value_q;
      tick_d     = 1'b0;
      if (run_press) begin
         state_d = (state_q == COUNTING) ? PAUSED : COUNTING;
      end
      if (state_q == COUNTING) begin
         presc_d = step ? '0 : presc_q + PW'(1);
      end
      if (step) begin
         value_d = step_value(value_q, dir_sync_q);
         tick_d  = 1'b1;
      end
      if (clr_press) begin
         value_d = INIT_VALUE;
         presc_d = '0;
         tick_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         dir_meta_q <= 1'b0;
         dir_sync_q <= 1'b0;
         state_q    <= PAUSED;
         presc_q    <= '0;
         value_q    <= INIT_VALUE;
         tick_q     <= 1'b0;
      end else begin
         dir_meta_q <= dir_meta_d;
         dir_sync_q <= dir_sync_d;
         state_q    <= state_d;
         presc_q    <= presc_d;
         value_q    <= value_d;
         tick_q     <= tick_d;
      end
   end

   assign VALUE   = value_q;
   assign TICK    = tick_q;
   assign RUNNING = (state_q == COUNTING);

endmodule

// File: tb/tb_hex_count_ctrl.sv
// Segment-table bench for hex_count_ctrl: each segment drives inputs for N cycles, then checks VALUE, RUNNING and tick count.
module tb_hex_count_ctrl;

   typedef struct {
      logic        rst;
      logic        run;
      logic        clr;
      logic        dir;
      int          cycles;
      logic [15:0] exp_value;
      logic        exp_running;
      int          exp_ticks;
   } vec_t;

   typedef struct {
      int          name_idx;
      logic [15:0] value;
      logic        running;
      int          ticks;
   } exp_t;

   logic        CLK     = 1'b0;
   logic        RST     = 1'b1;
   logic        BTN_RUN = 1'b0;
   logic        BTN_CLR = 1'b0;
   logic        DIR     = 1'b0;
   logic [15:0] VALUE;
   logic        TICK;
   logic        RUNNING;

   int    checks   = 0;
   int    errors   = 0;
   int    tick_cnt = 0;
   exp_t  exp_q[$];
   string names[$];
   vec_t  tbl[$];
   string tbl_name[$];

   hex_count_ctrl #(
      .TICK_DIV   (4),
      .DEB_CYCLES (3),
      .INIT_VALUE (16'hFFFE)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .BTN_RUN (BTN_RUN),
      .BTN_CLR (BTN_CLR),
      .DIR     (DIR),
      .VALUE   (VALUE),
      .TICK    (TICK),
      .RUNNING (RUNNING)
   );

   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not finish in time");
   end

   function automatic vec_t mk(input logic rst, input logic run, input logic clr, input logic dir,
                               input int cycles, input logic [15:0] val, input logic running,
                               input int ticks);
      vec_t v;
      v.rst         = rst;
      v.run         = run;
      v.clr         = clr;
      v.dir         = dir;
      v.cycles      = cycles;
      v.exp_value   = val;
      v.exp_running = running;
      v.exp_ticks   = ticks;
      return v;
   endfunction

   task automatic addVec(input string name, input vec_t v);
      tbl_name.push_back(name);
      tbl.push_back(v);
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
      if (TICK === 1'b1) tick_cnt++;
   endtask

   task automatic checkOutput();
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_empty got no expectation want one");
         return;
      end
      e = exp_q.pop_front();
      if (VALUE !== e.value) begin
         errors++;
         $display("[TB] FAIL %s value got %h want %h", names[e.name_idx], VALUE, e.value);
      end
      checks++;
      if (RUNNING !== e.running) begin
         errors++;
         $display("[TB] FAIL %s running got %b want %b", names[e.name_idx], RUNNING, e.running);
      end
      checks++;
      if (tick_cnt != e.ticks) begin
         errors++;
         $display("[TB] FAIL %s ticks got %0d want %0d", names[e.name_idx], tick_cnt, e.ticks);
      end
   endtask

   task automatic applyStimulus(input string name, input vec_t v);
      exp_t e;
      RST     = v.rst;
      BTN_RUN = v.run;
      BTN_CLR = v.clr;
      DIR     = v.dir;
      names.push_back(name);
      e.name_idx = names.size() - 1;
      e.value    = v.exp_value;
      e.running  = v.exp_running;
      e.ticks    = v.exp_ticks;
      exp_q.push_back(e);
      tick_cnt = 0;
      repeat (v.cycles) cyc();
      checkOutput();
   endtask

   initial begin
      //                      rst  run  clr  dir  cyc  value      run  ticks
      addVec("reset",         mk(1, 0, 0, 0,  2, 16'hFFFE, 0, 0));
      addVec("idle",          mk(0, 0, 0, 0, 20, 16'hFFFE, 0, 0));
      addVec("run_press",     mk(0, 1, 0, 0,  7, 16'hFFFE, 1, 0));
      addVec("up_step1",      mk(0, 0, 0, 0,  4, 16'hFFFF, 1, 1));
      addVec("up_wrap",       mk(0, 0, 0, 0,  4, 16'h0000, 1, 1));
      addVec("up_step3",      mk(0, 0, 0, 0,  4, 16'h0001, 1, 1));
      addVec("down_step",     mk(0, 0, 0, 1,  4, 16'h0000, 1, 1));
      addVec("down_wrap",     mk(0, 0, 0, 1,  4, 16'hFFFF, 1, 1));
      addVec("pre_pause",     mk(0, 0, 0, 1,  3, 16'hFFFF, 1, 0));
      addVec("pause_held",    mk(0, 1, 0, 1,  5, 16'hFFFD, 1, 2));
      addVec("pause_take",    mk(0, 0, 0, 1,  2, 16'hFFFD, 0, 0));
      addVec("paused_idle",   mk(0, 0, 0, 1, 10, 16'hFFFD, 0, 0));
      addVec("resume_held",   mk(0, 1, 0, 1,  5, 16'hFFFD, 0, 0));
      addVec("resume_pulse",  mk(0, 0, 0, 1,  1, 16'hFFFD, 0, 0));
      addVec("resume_take",   mk(0, 0, 0, 1,  1, 16'hFFFD, 1, 0));
      addVec("resume_2to3",   mk(0, 0, 0, 1,  1, 16'hFFFD, 1, 0));
      addVec("resume_wrap",   mk(0, 0, 0, 1,  1, 16'hFFFC, 1, 1));

      $display("[TB] table phase: %0d segments", tbl.size());
      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl_name[i], tbl[i]);
      end

      $display("[TB] bounce on run button then a clean held press");
      applyStimulus("bounce_hi1",    mk(0, 1, 0, 1,  2, 16'hFFFC, 1, 0));
      applyStimulus("bounce_lo",     mk(0, 0, 0, 1,  1, 16'hFFFC, 1, 0));
      applyStimulus("bounce_hi2",    mk(0, 1, 0, 1,  2, 16'hFFFB, 1, 1));
      applyStimulus("bounce_settle", mk(0, 0, 0, 1,  6, 16'hFFFA, 1, 1));
      applyStimulus("held_toggle",   mk(0, 1, 0, 1,  5, 16'hFFF8, 1, 2));
      applyStimulus("held_release",  mk(0, 0, 0, 1,  2, 16'hFFF8, 0, 0));
      applyStimulus("held_idle",     mk(0, 0, 0, 1, 12, 16'hFFF8, 0, 0));

      $display("[TB] clear aligned to a step cycle");
      applyStimulus("clr_run_a",     mk(0, 1, 0, 1,  2, 16'hFFF8, 0, 0));
      applyStimulus("clr_run_b",     mk(0, 1, 1, 1,  3, 16'hFFF8, 0, 0));
      applyStimulus("clr_resumed",   mk(0, 0, 1, 1,  2, 16'hFFF8, 1, 0));
      applyStimulus("clr_pre_step",  mk(0, 0, 0, 1,  1, 16'hFFF8, 1, 0));
      applyStimulus("clr_on_step",   mk(0, 0, 0, 1,  1, 16'hFFFE, 1, 0));
      applyStimulus("clr_gap",       mk(0, 0, 0, 1,  3, 16'hFFFE, 1, 0));
      applyStimulus("clr_next_tick", mk(0, 0, 0, 1,  1, 16'hFFFD, 1, 1));

      $display("[TB] reset while counting with run held");
      applyStimulus("rst_counting",  mk(1, 1, 0, 1,  1, 16'hFFFE, 0, 0));
      applyStimulus("rst_held_wait", mk(0, 1, 0, 1,  6, 16'hFFFE, 0, 0));
      applyStimulus("rst_held_tog",  mk(0, 1, 0, 1,  1, 16'hFFFE, 1, 0));
      applyStimulus("rst_held_run",  mk(0, 1, 0, 1, 10, 16'hFFFC, 1, 2));
      applyStimulus("rst_release",   mk(0, 0, 0, 1,  2, 16'hFFFB, 1, 1));

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
